reg_file_2r1w: RTL and testbench



---
 rtl/riscv_pkg.sv | 12 +
 rtl/regfile_entry.sv | 23 ++
 rtl/reg_file_2r1w.sv | 70 +++++++
 tb/tb_reg_file_2r1w.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V architectural constants
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [AW-1:0] REG_ZERO = AW'(0);
  localparam logic [AW-1:0] REG_RA   = AW'(1);
  localparam logic [AW-1:0] REG_SP   = AW'(2);

endpackage

// File: rtl/regfile_entry.sv
// rtl/regfile_entry.sv - one architectural register with sync reset and load enable
module regfile_entry
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset takes priority so a WB write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - integer register file, two combinational reads, one sync write
module reg_file_2r1w #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  import riscv_pkg::*;

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] wr_en;
  logic             byp_active;

  always_comb begin
    wr_en = '0;
    if (reg_write && (rd_addr != ZERO_ADDR)) begin
      wr_en[rd_addr] = 1'b1;
    end
  end

  // x0 is hardwired; it has no storage at all.
  assign regs[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    regfile_entry #(
      .W(XLEN)
    ) u_entry (
      .clk  (clk),
      .reset(reset),
      .load (wr_en[i]),
      .d    (rd_data),
      .q    (regs[i])
    );
  end

  // Forwarding is gated by reset so a cleared file never exposes the WB value.
  assign byp_active = (BYPASS != 0) && !reset && reg_write;

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == ZERO_ADDR) begin
      rs1_data = '0;
    end else if (byp_active && (rd_addr == rs1_addr)) begin
      rs1_data = rd_data;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == ZERO_ADDR) begin
      rs2_data = '0;
    end else if (byp_active && (rd_addr == rs2_addr)) begin
      rs2_data = rd_data;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - scoreboard bench for reg_file_2r1w, bypass and non-bypass builds
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        reg_write;
  logic [31:0] rd_data;
  logic [31:0] rs1_b1, rs2_b1, rs1_b0, rs2_b0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_b1), .rs2_data(rs2_b1),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  reg_file_2r1w #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_b0), .rs2_data(rs2_b0),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];
  bit          model_valid = 0;

  // port: 0 = bypass rs1, 1 = bypass rs2, 2 = no-bypass rs1, 3 = no-bypass rs2
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.port)
        0:       act = rs1_b1;
        1:       act = rs2_b1;
        2:       act = rs1_b0;
        default: act = rs2_b0;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp, input bit rst,
                                         input bit we, input logic [4:0] rd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (byp && !rst && we && (rd == a)) return wd;
    return model[a];
  endfunction

  task automatic push(input string name, input int port, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = val;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit we, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input string tag);
    reset     = rst;
    reg_write = we;
    rd_addr   = rd;
    rd_data   = wd;
    rs1_addr  = a1;
    rs2_addr  = a2;
    if (model_valid) begin
      push(tag, 0, exp_rd(a1, 1, rst, we, rd, wd));
      push(tag, 1, exp_rd(a2, 1, rst, we, rd, wd));
      push(tag, 2, exp_rd(a1, 0, rst, we, rd, wd));
      push(tag, 3, exp_rd(a2, 0, rst, we, rd, wd));
    end
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
      model_valid = 1;
    end else if (we && rd != 5'd0) begin
      model[rd] = wd;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    #1;

    // reset clears a previously written register and the whole file
    step(1, 0, 0, 0, 0, 0, "init_reset");
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, "wr_x5");
    step(1, 0, 0, 0, 5, 5, "reset_x5");
    push("rst_x5", 0, 32'h0);
    push("rst_x5", 2, 32'h0);
    step(0, 0, 0, 0, 5, 0, "rd_x5");
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i), "rst_all");
    end

    // ordinary writes, including the top register
    step(0, 1, 7, 32'h12345678, 0, 0, "wr_x7");
    step(0, 1, 31, 32'hFFFFFFFF, 0, 0, "wr_x31");
    push("rd_x7", 0, 32'h12345678);
    push("rd_x31", 1, 32'hFFFFFFFF);
    push("rd_x7_nb", 2, 32'h12345678);
    push("rd_x31_nb", 3, 32'hFFFFFFFF);
    step(0, 0, 0, 0, 7, 31, "rd_7_31");
    push("x6_zero", 0, 32'h0);
    step(0, 0, 0, 0, 6, 6, "rd_x6");

    // x0 stays zero with a write pending and afterwards
    push("x0_same", 0, 32'h0);
    push("x0_same_nb", 2, 32'h0);
    step(0, 1, 0, 32'hA5A5A5A5, 0, 0, "wr_x0");
    push("x0_next", 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, "rd_x0");

    // same-cycle forwarding vs. next-cycle visibility
    step(0, 1, 3, 32'h1, 0, 0, "wr_x3");
    push("byp_rs1", 0, 32'h2);
    push("byp_rs2", 1, 32'h2);
    push("nobyp_rs1", 2, 32'h1);
    push("nobyp_rs2", 3, 32'h1);
    step(0, 1, 3, 32'h2, 3, 3, "byp_x3");
    push("nobyp_after", 2, 32'h2);
    step(0, 0, 0, 0, 3, 3, "rd_x3");

    // reset beats a write in the same cycle and disables forwarding
    push("rstwr_during", 0, 32'h0);
    push("rstwr_during_nb", 2, 32'h0);
    step(1, 1, 9, 32'h55, 9, 9, "rst_wr_x9");
    push("rstwr_after", 0, 32'h0);
    push("rstwr_after_nb", 2, 32'h0);
    step(0, 0, 0, 0, 9, 9, "rd_x9");

    for (int n = 0; n < 4000; n++) begin
      bit          r_rst;
      bit          r_we;
      logic [4:0]  r_rd, r_a1, r_a2;
      r_rst = ($urandom_range(0, 63) == 0);
      r_we  = ($urandom_range(0, 3) != 0);
      r_rd  = 5'($urandom_range(0, 31));
      r_a1  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_a2  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      step(r_rst, r_we, r_rd, 32'($urandom()), r_a1, r_a2, "random");
    end

    reg_write = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
